// File: rtl/dna_align_pkg.sv
// Shared edit-command types for the alignment back end: opcode encodings and
// the scheduler FSM state type.
package dna_align_pkg;

    typedef logic [2:0] edit_op_t;

    localparam edit_op_t OP_DELETE = 3'b000;
    localparam edit_op_t OP_INSERT = 3'b001;
    localparam edit_op_t OP_KEEP   = 3'b010;
    localparam edit_op_t OP_NOP    = 3'b011;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEQ_B = 2'd1,
        SEQ_C = 2'd2,
        DONE  = 2'd3
    } sched_state_e;

endpackage

// File: rtl/edit_cmd_scheduler_classify.sv
// Combinational opcode classifier: flags defined opcodes (MSB clear) and the
// DO NOTHING opcode.
module edit_op_classify
    import dna_align_pkg::*;
(
    input  edit_op_t op_i,
    output logic     is_defined_o,
    output logic     is_nop_o
);

    assign is_defined_o = ~op_i[2];
    assign is_nop_o     = (op_i == OP_NOP);

endmodule

// File: rtl/edit_cmd_scheduler.sv
// Issues the snapshotted B then C edit-command vectors over a valid/ready port.
// Build option: EDIT_SKIP_NOP_EN suppresses DO NOTHING entries (one cycle each).
module edit_cmd_scheduler
    import dna_align_pkg::*;
#(
    parameter int LEN   = 7,
    parameter int IDX_W = $clog2(3*LEN+1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [0:3*LEN][0:2]      cmds_b,
    input  logic [0:3*LEN][0:2]      cmds_c,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_seq,
    output logic [IDX_W-1:0]         out_idx,
    output logic [2:0]               out_op,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic                     flag
);

    localparam int LAST = 3*LEN;

    sched_state_e        state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                err_q, err_d;
    logic [0:LAST][0:2]  snap_b_q, snap_c_q;

    edit_op_t cur_op;
    logic     cur_defined;
    logic     cur_nop;
    logic     in_seq;
    logic     skip;
    logic     hs;
    logic     advance;
    logic     at_last;

    assign in_seq = (state_q == SEQ_B) || (state_q == SEQ_C);
    assign cur_op = (state_q == SEQ_C) ? edit_op_t'(snap_c_q[idx_q])
                                       : edit_op_t'(snap_b_q[idx_q]);

    edit_op_classify u_classify (
        .op_i         (cur_op),
        .is_defined_o (cur_defined),
        .is_nop_o     (cur_nop)
    );

`ifdef EDIT_SKIP_NOP_EN
    assign skip = in_seq & cur_nop;
`else
    // DO NOTHING entries are presented like any other opcode in this build.
    assign skip = in_seq & cur_nop & 1'b0;
`endif

    assign out_valid = in_seq & ~skip;
    assign hs        = out_valid & out_ready;
    assign advance   = hs | skip;
    assign at_last   = (idx_q == IDX_W'(LAST));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SEQ_B;
                    idx_d   = '0;
                    err_d   = 1'b0;
                end
            end
            SEQ_B: begin
                if (advance) begin
                    if (at_last) begin
                        state_d = SEQ_C;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            SEQ_C: begin
                if (advance) begin
                    if (at_last) begin
                        state_d = DONE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
        // Undefined opcodes still go out; err marks the run once one is accepted.
        if (hs && !cur_defined) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
        end
    end

    // Snapshot is pure data; a stale copy is never visible because out_op is gated by state.
    always_ff @(posedge clk) begin
        if (state_q == IDLE && start) begin
            snap_b_q <= cmds_b;
            snap_c_q <= cmds_c;
        end
    end

    assign out_seq = (state_q == SEQ_C);
    assign out_idx = in_seq ? idx_q : '0;
    assign out_op  = in_seq ? cur_op : OP_DELETE;
    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);
    assign err     = err_q;
    assign flag    = (state_q == IDLE) || (state_q == DONE);

endmodule
